// File: rtl/multibyte_sub_seq.sv
// Serial multi-byte subtractor: A - B - borrow_in, one BYTE_W slice per clock, LS slice first.
// Optional zero/overflow flags are built when MULTIBYTE_SUB_FLAGS_EN is defined.
module multibyte_sub_seq #(
    parameter int unsigned BYTE_W     = 8,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic [BYTE_W*WORD_BYTES-1:0] word_a_i,
    input  logic [BYTE_W*WORD_BYTES-1:0] word_b_i,
    input  logic                         borrow_in_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [BYTE_W*WORD_BYTES-1:0] word_diff_o,
`ifdef MULTIBYTE_SUB_FLAGS_EN
    output logic                         zero_flag_o,
    output logic                         ovf_flag_o,
`endif
    output logic                         borrow_out_o
);

    localparam int unsigned IdxW = $clog2(WORD_BYTES);

    typedef logic [WORD_BYTES-1:0][BYTE_W-1:0] word_t;
    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    word_t           a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic            borrow_q, borrow_d;
    logic            borrow_out_q, borrow_out_d;
    logic [BYTE_W:0] byte_sub;
    logic            last_byte;

`ifdef MULTIBYTE_SUB_FLAGS_EN
    logic nonzero_q, nonzero_d;
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;
`endif

    // Extra MSB of the slice result is the borrow out of this slice.
    assign byte_sub  = {1'b0, a_q[idx_q]} - {1'b0, b_q[idx_q]} - {{BYTE_W{1'b0}}, borrow_q};
    assign last_byte = (idx_q == IdxW'(WORD_BYTES - 1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        a_d          = a_q;
        b_d          = b_q;
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
`ifdef MULTIBYTE_SUB_FLAGS_EN
        nonzero_d    = nonzero_q;
        zero_d       = zero_q;
        ovf_d        = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d       = word_a_i;
                    b_d       = word_b_i;
                    borrow_d  = borrow_in_i;
                    idx_d     = '0;
                    state_d   = StRun;
`ifdef MULTIBYTE_SUB_FLAGS_EN
                    nonzero_d = 1'b0;
`endif
                end
            end
            StRun: begin
                diff_d[idx_q] = byte_sub[BYTE_W-1:0];
                borrow_d      = byte_sub[BYTE_W];
`ifdef MULTIBYTE_SUB_FLAGS_EN
                nonzero_d     = nonzero_q | (|byte_sub[BYTE_W-1:0]);
`endif
                if (last_byte) begin
                    borrow_out_d = byte_sub[BYTE_W];
                    idx_d        = '0;
                    state_d      = StFin;
`ifdef MULTIBYTE_SUB_FLAGS_EN
                    zero_d = ~nonzero_d;
                    // Overflow only when operand signs differ and the result sign leaves A's sign.
                    ovf_d  = (a_q[WORD_BYTES-1][BYTE_W-1] != b_q[WORD_BYTES-1][BYTE_W-1]) &&
                             (byte_sub[BYTE_W-1] != a_q[WORD_BYTES-1][BYTE_W-1]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
`ifdef MULTIBYTE_SUB_FLAGS_EN
            nonzero_q    <= 1'b0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            a_q          <= a_d;
            b_q          <= b_d;
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
`ifdef MULTIBYTE_SUB_FLAGS_EN
            nonzero_q    <= nonzero_d;
            zero_q       <= zero_d;
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StFin);
    assign word_diff_o  = diff_q;
    assign borrow_out_o = borrow_out_q;
`ifdef MULTIBYTE_SUB_FLAGS_EN
    assign zero_flag_o  = zero_q;
    assign ovf_flag_o   = ovf_q;
`endif

endmodule

// File: tb/tb_multibyte_sub_seq.sv
// Bench for multibyte_sub_seq: directed and random operations against a whole-word arithmetic model.
module tb_multibyte_sub_seq;

    localparam int BW = 8;
    localparam int NB = 4;
    localparam int W  = BW * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         bin_in;
    logic         busy, done, bo;
    logic [W-1:0] diff;
`ifdef MULTIBYTE_SUB_FLAGS_EN
    logic         zf, of;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multibyte_sub_seq #(
        .BYTE_W     (BW),
        .WORD_BYTES (NB)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .start_i      (start),
        .word_a_i     (a_in),
        .word_b_i     (b_in),
        .borrow_in_i  (bin_in),
        .busy_o       (busy),
        .done_o       (done),
        .word_diff_o  (diff),
`ifdef MULTIBYTE_SUB_FLAGS_EN
        .zero_flag_o  (zf),
        .ovf_flag_o   (of),
`endif
        .borrow_out_o (bo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: {borrow, diff} of a - b - bin as unsigned integers.
    function automatic logic [W:0] model_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic bin);
        logic [W:0] full;
        logic       bor;
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        bor  = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, bin}));
        return {bor, full[W-1:0]};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input bit glitch, input string tag);
        logic [W:0] exp;
        int         cyc;
        exp = model_sub(a, b, bin);
        @(negedge clk);
        a_in = a; b_in = b; bin_in = bin; start = 1'b1;
        @(negedge clk);
        check({tag, "_busy_run"}, busy, 1);
        if (glitch) begin
            a_in = 32'h55;
        end else begin
            start  = 1'b0;
            a_in   = $urandom;
            b_in   = $urandom;
            bin_in = 1'($urandom_range(0, 1));
        end
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) start = 1'b0;
        end
        check({tag, "_latency"}, cyc, 5);
        check({tag, "_done"}, done, 1);
        check({tag, "_diff"}, diff, exp[W-1:0]);
        check({tag, "_borrow"}, bo, exp[W]);
`ifdef MULTIBYTE_SUB_FLAGS_EN
        check({tag, "_zero"}, zf, (exp[W-1:0] == '0));
        check({tag, "_ovf"}, of, (a[W-1] != b[W-1]) && (exp[W-1] != a[W-1]));
`endif
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_hold"}, diff, exp[W-1:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n_done;
        int t_first, t_second;
        logic [W:0] exp;

        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", bo, 0);
`ifdef MULTIBYTE_SUB_FLAGS_EN
        check("rst_zero", zf, 0);
        check("rst_ovf", of, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, "basic");
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, "ripple");
        run_op(32'h0000_0100, 32'h0000_0000, 1'b1, 1'b0, "bin_cross");
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, "equal");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, "signed_ovf");
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "pos_minus_neg");
        run_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "max_borrow");

        // Start re-pulsed while busy must be ignored.
        run_op(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, "busy_rule");
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("busy_rule_no_second", n_done, 0);
        check("busy_rule_diff_kept", diff, 32'h0000_000F);

        // Reset during the second RUN cycle aborts with no done.
        @(negedge clk);
        a_in = 32'hFFFF_0000; b_in = 32'h0000_1111; bin_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", bo, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_op(32'h1234_5678, 32'h0234_5678, 1'b0, 1'b0, "after_abort");

        // Start held high: one operation per NB+2 cycles.
        @(negedge clk);
        a_in = 32'h0001_0000; b_in = 32'h0000_0001; bin_in = 1'b0; start = 1'b1;
        t_first = -1; t_second = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                if (t_first < 0) t_first = i;
                else if (t_second < 0) t_second = i;
            end
        end
        start = 1'b0;
        check("throughput_spacing", t_second - t_first, NB + 2);
        check("throughput_diff", diff, 32'h0000_FFFF);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("throughput_idle", busy, 0);

        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (k % 6 == 0) rb = ra;
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, "random");
        end

        exp = model_sub(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, "equal_bin");
        check("equal_bin_all_ones", diff, exp[W-1:0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
